mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 152 +++++++++++++++
 tb/tb_mem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port word memory with word/byte access and a one-cycle ready pulse.
// Optional wait states are built only when MEM_WAIT_STATE_EN is defined.
module mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

`ifdef MEM_WAIT_STATE_EN
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] wait_cnt;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif

  state_t state, state_d;

  logic                  we_p0;
  logic [1:0]            mode_p0;
  logic [DEPTH_LOG2+1:0] addr_p0;
  logic [31:0]           wdata_p0;

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic [31:0]           word;
  logic [7:0]            byte_sel;
  logic [31:0]           rd_val;
  logic                  bad;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^addr[31:DEPTH_LOG2+2];

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0]  sb;
    logic signed [31:0] sx;
    sb = b;
    sx = sb;
    return sgn ? sx : {24'd0, b};
  endfunction

  assign idx  = addr_p0[DEPTH_LOG2+1:2];
  assign lane = addr_p0[1:0];
  assign bad  = (mode_p0 == 2'b11) || ((mode_p0 == 2'b00) && (lane != 2'b00));

  // Big-endian lanes: lane 0 is bits 31:24, lane 3 is bits 7:0
  always_comb begin
    word     = mem[idx];
    byte_sel = word[{~lane, 3'b111} -: 8];
    rd_val   = '0;
    case (mode_p0)
      2'b00:   rd_val = word;
      2'b01:   rd_val = ext_byte(byte_sel, 1'b1);
      2'b10:   rd_val = ext_byte(byte_sel, 1'b0);
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (req) begin
`ifdef MEM_WAIT_STATE_EN
          state_d = (WAIT_CYCLES != 0) ? WAIT : ACCESS;
`else
          state_d = ACCESS;
`endif
        end
      end
`ifdef MEM_WAIT_STATE_EN
      WAIT:    if (wait_cnt == CNT_W'(1)) state_d = ACCESS;
`endif
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: request capture in IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      we_p0    <= 1'b0;
      mode_p0  <= 2'b00;
      addr_p0  <= '0;
      wdata_p0 <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && req) begin
        we_p0    <= we;
        mode_p0  <= mode;
        addr_p0  <= addr[DEPTH_LOG2+1:0];
        wdata_p0 <= wdata;
      end
    end
  end

`ifdef MEM_WAIT_STATE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == IDLE && req) begin
      wait_cnt <= CNT_W'(WAIT_CYCLES);
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end
`endif

  // Stage p1: array access; response registers are live only in RESP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      if (state == ACCESS) begin
        ready <= 1'b1;
        err   <= bad;
        rdata <= (!bad && !we_p0) ? rd_val : 32'd0;
      end
    end
  end

  // Array is never reset; only the selected lane changes on a byte write
  always_ff @(posedge clk) begin
    if (state == ACCESS && we_p0 && !bad) begin
      if (mode_p0 == 2'b00) begin
        mem[idx] <= wdata_p0;
      end else begin
        mem[idx][{~lane, 3'b111} -: 8] <= wdata_p0[7:0];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a word-level reference model and a per-cycle output compare.
module tb_mem_responder;
  localparam int WC = 2;
`ifdef MEM_WAIT_STATE_EN
  localparam int LAT = 2 + WC;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  int errors = 0;
  int checks = 0;
  int edges = 0;
  int exp_edge = -1;
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] mm [int];

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .mode(mode), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: word array, big-endian lanes, alignment/mode errors
  task automatic model_access(input logic w, input logic [1:0] m, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] rd, output logic e);
    int idx;
    int ln;
    int sh;
    logic [31:0] cur;
    logic [31:0] b;
    idx = int'((a / 4) % 256);
    ln  = int'(a % 4);
    sh  = 8 * (3 - ln);
    e   = (m == 2'd3) || (m == 2'd0 && ln != 0);
    rd  = '0;
    cur = mm.exists(idx) ? mm[idx] : 32'd0;
    if (!e) begin
      if (w) begin
        if (m == 2'd0) mm[idx] = d;
        else mm[idx] = (cur & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      end else begin
        b = (cur >> sh) & 32'hFF;
        if (m == 2'd0) rd = cur;
        else if (m == 2'd1 && b >= 128) rd = b | 32'hFFFF_FF00;
        else rd = b;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!hold) begin
      if (edges == exp_edge) begin
        check("cyc_ready", {31'd0, ready}, 32'd1);
        check("cyc_err", {31'd0, err}, {31'd0, exp_err});
        check("cyc_rdata", rdata, exp_rdata);
      end else begin
        check("idle_ready", {31'd0, ready}, 32'd0);
        check("idle_err", {31'd0, err}, 32'd0);
        check("idle_rdata", rdata, 32'd0);
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that leaves RESP
  task automatic do_req(input logic w, input logic [1:0] m, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic e);
    int lat;
    logic [31:0] mr;
    logic me;
    req = 1'b1; we = w; mode = m; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; mode = 2'b00; addr = '0; wdata = '0;
    model_access(w, m, a, d, mr, me);
    exp_rdata = mr;
    exp_err   = me;
    exp_edge  = edges + LAT - 1;
    lat = 1;
    while (!ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, LAT);
    rd = rdata;
    e  = err;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic e;
    int pulses;
    int first_pulse;
    int second_pulse;
    reset = 1'b1; req = 1'b0; we = 1'b0; mode = 2'b00; addr = '0; wdata = '0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    reset = 1'b1;

    do_req(1'b1, 2'b00, 32'h10, 32'h1234_5678, rd, e);
    check("wr_word_rdata", rd, 32'h0);
    check("wr_word_err", {31'd0, e}, 32'd0);
    do_req(1'b0, 2'b00, 32'h10, 32'h0, rd, e);
    check("rd_word", rd, 32'h1234_5678);
    check("rd_word_err", {31'd0, e}, 32'd0);

    do_req(1'b1, 2'b00, 32'h20, 32'h80FF_017F, rd, e);
    do_req(1'b0, 2'b01, 32'h20, 32'h0, rd, e);
    check("sbyte_20", rd, 32'hFFFF_FF80);
    do_req(1'b0, 2'b10, 32'h20, 32'h0, rd, e);
    check("ubyte_20", rd, 32'h0000_0080);
    do_req(1'b0, 2'b01, 32'h23, 32'h0, rd, e);
    check("sbyte_23", rd, 32'h0000_007F);
    do_req(1'b0, 2'b01, 32'h21, 32'h0, rd, e);
    check("sbyte_21", rd, 32'hFFFF_FFFF);
    do_req(1'b0, 2'b10, 32'h22, 32'h0, rd, e);
    check("ubyte_22", rd, 32'h0000_0001);

    do_req(1'b1, 2'b00, 32'h30, 32'hAABB_CCDD, rd, e);
    do_req(1'b1, 2'b01, 32'h31, 32'h0000_0011, rd, e);
    do_req(1'b0, 2'b00, 32'h30, 32'h0, rd, e);
    check("byte_lane_wr", rd, 32'hAA11_CCDD);

    do_req(1'b0, 2'b00, 32'h02, 32'h0, rd, e);
    check("misalign_rd_err", {31'd0, e}, 32'd1);
    check("misalign_rd_data", rd, 32'h0);
    do_req(1'b1, 2'b00, 32'h40, 32'hCAFE_F00D, rd, e);
    do_req(1'b1, 2'b00, 32'h42, 32'h0000_DEAD, rd, e);
    check("misalign_wr_err", {31'd0, e}, 32'd1);
    do_req(1'b0, 2'b00, 32'h40, 32'h0, rd, e);
    check("misalign_wr_keep", rd, 32'hCAFE_F00D);
    do_req(1'b0, 2'b11, 32'h40, 32'h0, rd, e);
    check("mode11_err", {31'd0, e}, 32'd1);
    check("mode11_data", rd, 32'h0);

    do_req(1'b1, 2'b00, 32'h400, 32'h0BEE_F123, rd, e);
    do_req(1'b0, 2'b00, 32'h000, 32'h0, rd, e);
    check("wrap_400", rd, 32'h0BEE_F123);

    // Abort a write by resetting right after it is accepted
    do_req(1'b1, 2'b00, 32'h50, 32'h5555_AAAA, rd, e);
    req = 1'b1; we = 1'b1; mode = 2'b00; addr = 32'h50; wdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    req = 1'b0;
    reset = 1'b0;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    do_req(1'b0, 2'b00, 32'h50, 32'h0, rd, e);
    check("abort_keep", rd, 32'h5555_AAAA);

    // Held req: two back-to-back responses
    hold = 1'b1;
    pulses = 0; first_pulse = 0; second_pulse = 0;
    req = 1'b1; we = 1'b0; mode = 2'b00; addr = 32'h10; wdata = '0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        pulses++;
        check("hold_rdata", rdata, 32'h1234_5678);
        if (pulses == 1) first_pulse = i;
        if (pulses == 2) begin
          second_pulse = i;
          req = 1'b0;
        end
      end
    end
    req = 1'b0;
    check("hold_pulses", pulses, 32'd2);
    check("hold_gap", second_pulse - first_pulse, LAT + 1);
    @(negedge clk);
    hold = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
